// File: rtl/cloud_scheduler.sv
// ---------------------------------------------------------------------------
// cloud_scheduler
//
// Moves a small set of background clouds horizontally across the screen.
// Once every FRAME_DIV enabled frames, each cloud's left edge is advanced
// by the selected speed, wrapping modulo XWRAP. The clouds are updated one
// at a time into working registers. All new positions are then published
// together, so the renderer never sees a half-updated set.
//
// Optional feature (macro CLOUD_GUST_EN):
//   When this macro is defined, an 8-bit LFSR produces occasional "gusts".
//   During a gust, every cloud moves one pixel further than the speed input
//   asks for on that update.
//
// Parameters:
//   N_CLOUDS  - number of clouds (1..8)
//   XWRAP     - horizontal modulus (screen width + cloud width)
//   FRAME_DIV - enabled frames per position update (1..15)
//   Y_BASE    - top edge of cloud 0
//   Y_STEP    - vertical spacing between consecutive clouds
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   vblnk      - vertical blanking; its rising edge marks a new frame
//   enable     - 1 lets the clouds drift, 0 freezes them
//   speed      - pixels added per update
//   cloud_x    - committed left-edge positions, origin at screen x = -512
//   cloud_y    - constant top-edge positions
//   upd_strobe - one-cycle pulse that coincides with a new cloud_x set
//   busy       - high while an update sequence is in progress
// ---------------------------------------------------------------------------
module cloud_scheduler #(
    parameter int N_CLOUDS  = 4,
    parameter int XWRAP     = 1536,
    parameter int FRAME_DIV = 2,
    parameter int Y_BASE    = 64,
    parameter int Y_STEP    = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vblnk,
    input  logic                       enable,
    input  logic [2:0]                 speed,
    output logic [N_CLOUDS-1:0][10:0]  cloud_x,
    output logic [N_CLOUDS-1:0][9:0]   cloud_y,
    output logic                       upd_strobe,
    output logic                       busy
);

    localparam int IDX_W   = (N_CLOUDS > 1) ? $clog2(N_CLOUDS) : 1;
    localparam int SPACING = XWRAP / N_CLOUDS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLOUDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        UPDATE,
        COMMIT
    } state_t;

    state_t                     state_q, state_d;
    logic                       vblnk_q, vblnk_prev_q;
    logic [3:0]                 div_q, div_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [N_CLOUDS-1:0][10:0]  work_x_q, work_x_d;
    logic [N_CLOUDS-1:0][10:0]  cloud_x_q, cloud_x_d;
    logic                       upd_strobe_q, upd_strobe_d;

    logic                       frame_tick;
    logic [3:0]                 eff_speed;
    logic [11:0]                sum;
    logic [10:0]                next_x;

`ifdef CLOUD_GUST_EN
    logic [7:0]                 lfsr_q, lfsr_d;
`endif

    // A frame starts when the registered vblnk rises. The input is first
    // passed through one register stage, and the edge is detected on that
    // registered copy.
    assign frame_tick = vblnk_q & ~vblnk_prev_q;

    assign cloud_x    = cloud_x_q;
    assign upd_strobe = upd_strobe_q;
    assign busy       = (state_q != IDLE);

    // The vertical positions are fixed and depend only on the cloud index.
    for (genvar g = 0; g < N_CLOUDS; g++) begin : g_cloud_y
        assign cloud_y[g] = 10'(Y_BASE + g * Y_STEP);
    end

    // Compute the speed for this update. In a gust, each cloud moves one
    // extra pixel. The LFSR has already advanced on the way into COUNT, so
    // every cloud in this update uses the same gust decision.
    always_comb begin
`ifdef CLOUD_GUST_EN
        eff_speed = {1'b0, speed} + {3'b000, &lfsr_q[1:0]};
`else
        eff_speed = {1'b0, speed};
`endif
    end

    // One shared adder serves the cloud currently selected by idx_q. The
    // sum needs 12 bits so that an overflow past XWRAP can be detected
    // before it is wrapped back into range.
    always_comb begin
        sum    = {1'b0, work_x_q[idx_q]} + {8'd0, eff_speed};
        next_x = (sum >= 12'(XWRAP)) ? 11'(sum - 12'(XWRAP)) : sum[10:0];
    end

    // Sequencer. The divider only counts frames that arrive while the block
    // is enabled. The working copy is updated one cloud per cycle, and the
    // published positions change only in COMMIT.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        idx_d        = idx_q;
        work_x_d     = work_x_q;
        cloud_x_d    = cloud_x_q;
        upd_strobe_d = 1'b0;
`ifdef CLOUD_GUST_EN
        lfsr_d       = lfsr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (frame_tick && enable) begin
                    state_d = COUNT;
`ifdef CLOUD_GUST_EN
                    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                end
            end
            COUNT: begin
                if (div_q + 4'd1 == 4'(FRAME_DIV)) begin
                    div_d   = 4'd0;
                    idx_d   = '0;
                    state_d = UPDATE;
                end else begin
                    div_d   = div_q + 4'd1;
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                work_x_d[idx_q] = next_x;
                if (idx_q == LAST_IDX) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            COMMIT: begin
                cloud_x_d    = work_x_q;
                upd_strobe_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset places the clouds at evenly
    // spaced starting positions and discards any update that was in
    // progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vblnk_q      <= 1'b0;
            vblnk_prev_q <= 1'b0;
            div_q        <= 4'd0;
            idx_q        <= '0;
            upd_strobe_q <= 1'b0;
            for (int i = 0; i < N_CLOUDS; i++) begin
                work_x_q[i]  <= 11'(i * SPACING);
                cloud_x_q[i] <= 11'(i * SPACING);
            end
`ifdef CLOUD_GUST_EN
            lfsr_q       <= 8'hA5;
`endif
        end else begin
            state_q      <= state_d;
            vblnk_q      <= vblnk;
            vblnk_prev_q <= vblnk_q;
            div_q        <= div_d;
            idx_q        <= idx_d;
            upd_strobe_q <= upd_strobe_d;
            work_x_q     <= work_x_d;
            cloud_x_q    <= cloud_x_d;
`ifdef CLOUD_GUST_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

endmodule

// File: tb/tb_cloud_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cloud_scheduler
//
// Self-checking bench for cloud_scheduler with its default parameters.
// A behavioural model keeps the following state:
//   - cloud positions as plain integers, wrapped with a modulo operation
//   - the frame divider as a simple counter
//   - the gust LFSR, when CLOUD_GUST_EN is defined
// Each frame, the bench predicts whether an update should occur, when
// upd_strobe should appear, and the cloud_x values that should result.
// ---------------------------------------------------------------------------
module tb_cloud_scheduler;

    localparam int N_CLOUDS  = 4;
    localparam int XWRAP     = 1536;
    localparam int FRAME_DIV = 2;
    localparam int FRAME_LEN = 16;
    // Count from the cycle in which vblnk is driven high. One cycle goes to
    // registering vblnk. The remaining N_CLOUDS+3 cycles are the latency
    // from the frame tick to upd_strobe.
    localparam int STROBE_AT = 1 + N_CLOUDS + 3;

    logic                      clk;
    logic                      rst;
    logic                      vblnk;
    logic                      enable;
    logic [2:0]                speed;
    logic [N_CLOUDS-1:0][10:0] cloud_x;
    logic [N_CLOUDS-1:0][9:0]  cloud_y;
    logic                      upd_strobe;
    logic                      busy;

    int checks;
    int failures;
    int strobe_total;

    int model_x[N_CLOUDS];
    int model_div;
    int model_lfsr;

    cloud_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .enable     (enable),
        .speed      (speed),
        .cloud_x    (cloud_x),
        .cloud_y    (cloud_y),
        .upd_strobe (upd_strobe),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value, and log a
    // line whenever the two differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Return the model to its reset state.
    task automatic modelReset();
        for (int i = 0; i < N_CLOUDS; i++) model_x[i] = i * (XWRAP / N_CLOUDS);
        model_div  = 0;
        model_lfsr = 'hA5;
    endtask

    // Apply one frame tick to the model. Return 1 if this frame should
    // produce a committed update.
    function automatic bit modelTick(input bit en, input int spd);
        int eff;
        if (!en) return 0;
        model_lfsr = ((model_lfsr << 1) & 'hFF) |
                     (((model_lfsr >> 7) ^ (model_lfsr >> 5) ^
                       (model_lfsr >> 4) ^ (model_lfsr >> 3)) & 1);
        model_div++;
        if (model_div != FRAME_DIV) return 0;
        model_div = 0;
`ifdef CLOUD_GUST_EN
        eff = spd + (((model_lfsr & 3) == 3) ? 1 : 0);
`else
        eff = spd;
`endif
        for (int i = 0; i < N_CLOUDS; i++) model_x[i] = (model_x[i] + eff) % XWRAP;
        return 1;
    endfunction

    task automatic checkAllX(input string tag);
        for (int i = 0; i < N_CLOUDS; i++)
            checkOutput($sformatf("%s x[%0d]", tag, i), 32'(cloud_x[i]), 32'(model_x[i]));
    endtask

    // Run one complete frame. Raise vblnk, watch for upd_strobe within the
    // frame window, and compare the timing and final positions against the
    // model.
    task automatic applyStimulus(input bit en, input logic [2:0] spd);
        int  old_x[N_CLOUDS];
        bit  upd;
        int  seen;
        int  seen_at;
        for (int i = 0; i < N_CLOUDS; i++) old_x[i] = model_x[i];
        enable = en;
        speed  = spd;
        vblnk  = 1'b1;
        upd    = modelTick(en, int'(spd));
        seen   = 0;
        seen_at = -1;
        for (int c = 1; c <= FRAME_LEN; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) checkOutput("busy in COUNT", 32'(busy), 32'(en));
            if (c == 3) vblnk = 1'b0;
            if (c == STROBE_AT - 1)
                for (int i = 0; i < N_CLOUDS; i++)
                    checkOutput("no early x change", 32'(cloud_x[i]), 32'(old_x[i]));
            if (upd_strobe) begin
                seen++;
                if (seen_at < 0) seen_at = c;
            end
        end
        strobe_total += seen;
        checkOutput("strobe count", 32'(seen), 32'(upd));
        if (upd) checkOutput("strobe latency", 32'(seen_at), 32'(STROBE_AT));
        checkAllX("frame");
    endtask

    // Start an update frame, then apply reset while the third cloud is
    // being processed. The partial update must be discarded.
    task automatic resetDuringUpdate();
        int seen;
        enable = 1'b1;
        speed  = 3'd3;
        vblnk  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("busy in UPDATE", 32'(busy), 32'd1);
        rst   = 1'b1;
        vblnk = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkOutput("busy after rst", 32'(busy), 32'd0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (upd_strobe) seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("no strobe after rst", 32'(seen), 32'd0);
        checkAllX("after mid rst");
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        strobe_total = 0;
        rst    = 1'b1;
        vblnk  = 1'b0;
        enable = 1'b0;
        speed  = 3'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Check the reset state, including the constant vertical positions.
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset strobe", 32'(upd_strobe), 32'd0);
        for (int i = 0; i < N_CLOUDS; i++)
            checkOutput("reset x", 32'(cloud_x[i]), 32'(i * 384));
        for (int i = 0; i < N_CLOUDS; i++)
            checkOutput("cloud_y", 32'(cloud_y[i]), 32'(64 + i * 40));

        // Four enabled frames at speed 3 should produce two updates.
        strobe_total = 0;
        repeat (4) applyStimulus(1'b1, 3'd3);
        checkOutput("strobes in 4 frames", 32'(strobe_total), 32'd2);
`ifndef CLOUD_GUST_EN
        checkOutput("x0 after 2 updates", 32'(cloud_x[0]), 32'd6);
`endif

        // While disabled, positions stay frozen. After re-enabling, the
        // model predicts when the next update should occur.
        strobe_total = 0;
        repeat (10) applyStimulus(1'b0, 3'd5);
        checkOutput("strobes while disabled", 32'(strobe_total), 32'd0);
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd1);
        checkOutput("strobes after re-enable", 32'(strobe_total), 32'd1);

        // Advance so the next tick triggers an update, then reset mid-update.
        applyStimulus(1'b1, 3'd2);
        resetDuringUpdate();

        // Drive cloud 3 from 1152 to 1534, then wrap it with speed 5.
        repeat (54) begin
            applyStimulus(1'b1, 3'd7);
            applyStimulus(1'b1, 3'd7);
        end
        applyStimulus(1'b1, 3'd4);
        applyStimulus(1'b1, 3'd4);
`ifndef CLOUD_GUST_EN
        checkOutput("x3 before wrap", 32'(cloud_x[3]), 32'd1534);
`endif
        applyStimulus(1'b1, 3'd5);
        applyStimulus(1'b1, 3'd5);
`ifndef CLOUD_GUST_EN
        checkOutput("x3 after wrap", 32'(cloud_x[3]), 32'd3);
`endif

        // Random traffic, using a fixed speed of 2 in the gust build.
        for (int f = 0; f < 150; f++) begin
`ifdef CLOUD_GUST_EN
            applyStimulus(bit'($urandom_range(0, 3) != 0), 3'd2);
`else
            applyStimulus(bit'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Watchdog that ends a runaway simulation.
    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
